bcd_timer_display: RTL and testbench

Parametrised N-digit BCD elapsed-time counter with a built-in multiplexed seven-segment driver, the generalised successor to the fixed two-digit tens/ones display path in the Tiny Tapeout game top. It owns the time-base prescaler, start/stop/clear control, the saturating or wrapping BCD count, and the scanned display outputs, with optional leading-zero blanking and active-low outputs. Game logic drives only the command strobes and reads back `count_bcd`, `running` and `overflow`.

---
 rtl/bcd_timer_display.sv | 167 ++++++++++++++++
 tb/tb_bcd_timer_display.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_display.sv
// N-digit BCD elapsed-time counter with start/stop/clear control and a
// registered, scanned seven-segment driver (optional leading-zero blanking).
module bcd_timer_display #(
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned TICK_DIV   = 2_000_000,
  parameter int unsigned SCAN_DIV   = 4,
  parameter bit          SATURATE   = 1'b1,
  parameter bit          LZB        = 1'b0,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  running,
  output logic                  overflow
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{ACTIVE_LOW}};

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                state_q;
  logic [TICK_W-1:0]     presc_q;
  logic [4*DIGITS-1:0]   count_q;
  logic                  ovf_q;
  logic [SCAN_W-1:0]     scan_q;
  logic [IDX_W-1:0]      idx_q;
  logic [6:0]            seg_q;
  logic [DIGITS-1:0]     sel_q;

  logic [4*DIGITS-1:0]   count_inc;
  logic                  all_nines;
  logic                  tick;
  logic [3:0]            cur_digit;
  logic [DIGITS-1:0]     upper_zero;
  logic                  zero_acc;
  logic                  blank_cur;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Ripple carry through the digits; a carry out of the top digit means all-9s,
  // and in that case count_inc is already all zeros (the wrap value).
  always_comb begin
    count_inc = count_q;
    all_nines = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (all_nines) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          all_nines           = 1'b0;
        end
      end
    end
  end

  assign tick = (state_q == ST_RUN) && (presc_q == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= (state_q == ST_RUN && !tick) ? presc_q + TICK_W'(1) : '0;
      if (clear) begin
        state_q <= ST_IDLE;
        presc_q <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (stop) begin
        state_q <= ST_IDLE;
        presc_q <= '0;
      end else if (start && state_q == ST_IDLE && !(SATURATE && ovf_q)) begin
        state_q <= ST_RUN;
      end else if (tick) begin
        if (all_nines) begin
          ovf_q <= 1'b1;
        end
        if (all_nines && SATURATE) begin
          state_q <= ST_IDLE;
        end else begin
          count_q <= count_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q <= '0;
      idx_q  <= '0;
    end else if (scan_q == SCAN_LAST) begin
      scan_q <= '0;
      idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
    end
  end

  // upper_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    cur_digit  = '0;
    upper_zero = '0;
    zero_acc   = 1'b1;
    blank_cur  = blank;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_acc                 = zero_acc && (count_q[4*(DIGITS-1-k) +: 4] == 4'd0);
      upper_zero[DIGITS-1-k]   = zero_acc;
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = count_q[4*i +: 4];
        if (LZB && i > 0 && upper_zero[i]) begin
          blank_cur = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      sel_q <= SEL_OFF;
    end else begin
      seg_q <= (blank_cur ? 7'b0000000 : seg7(cur_digit)) ^ SEG_OFF;
      sel_q <= (DIGITS'(1) << idx_q) ^ SEL_OFF;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = sel_q;
  assign count_bcd = count_q;
  assign running   = (state_q == ST_RUN);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_timer_display.sv
// Bench for bcd_timer_display: two instances (saturating/plain and
// wrapping/LZB/active-low) checked every cycle against an integer-count model.
module tb_bcd_timer_display;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned SCAN_DIV = 2;

  logic clk = 1'b0;
  logic reset, start, stop, clear, blank;

  logic [6:0] seg_a, seg_b;
  logic [1:0] sel_a, sel_b;
  logic [7:0] cnt_a, cnt_b;
  logic       run_a, run_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  bcd_timer_display #(
    .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
    .SATURATE(1'b1), .LZB(1'b0), .ACTIVE_LOW(1'b0)
  ) u_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .blank(blank), .seg(seg_a), .digit_sel(sel_a), .count_bcd(cnt_a),
    .running(run_a), .overflow(ovf_a)
  );

  bcd_timer_display #(
    .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
    .SATURATE(1'b0), .LZB(1'b1), .ACTIVE_LOW(1'b1)
  ) u_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .blank(blank), .seg(seg_b), .digit_sel(sel_b), .count_bcd(cnt_b),
    .running(run_b), .overflow(ovf_b)
  );

  bit msat[2] = '{1'b1, 1'b0};
  bit mlzb[2] = '{1'b0, 1'b1};
  bit mal[2]  = '{1'b0, 1'b1};

  logic [6:0] segtab[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111};

  int         m_count[2];
  bit         m_run[2];
  bit         m_ovf[2];
  int         m_el[2];
  int         m_cyc;
  logic [6:0] e_seg[2];
  logic [1:0] e_sel[2];

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_count[k] = 0;
      m_run[k]   = 1'b0;
      m_ovf[k]   = 1'b0;
      m_el[k]    = 0;
      e_seg[k]   = mal[k] ? 7'h7f : 7'h00;
      e_sel[k]   = mal[k] ? 2'b11 : 2'b00;
    end
    m_cyc = 0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    int  idx;
    int  pw;
    int  dig;
    bit  blk;
    bit  was_run;
    bit  tk;
    int  maxv;
    if (reset) begin
      model_reset();
      return;
    end
    idx  = (m_cyc / SCAN_DIV) % DIGITS;
    pw   = 1;
    repeat (idx) pw = pw * 10;
    maxv = 1;
    repeat (DIGITS) maxv = maxv * 10;
    maxv = maxv - 1;
    for (int k = 0; k < 2; k++) begin
      dig      = (m_count[k] / pw) % 10;
      blk      = blank || (mlzb[k] && idx > 0 && m_count[k] < pw);
      e_seg[k] = (blk ? 7'h00 : segtab[dig]) ^ (mal[k] ? 7'h7f : 7'h00);
      e_sel[k] = 2'(1 << idx) ^ (mal[k] ? 2'b11 : 2'b00);

      was_run = m_run[k];
      tk      = was_run && ((m_el[k] + 1) % TICK_DIV == 0);
      if (clear) begin
        m_count[k] = 0;
        m_ovf[k]   = 1'b0;
        m_run[k]   = 1'b0;
      end else if (stop) begin
        m_run[k] = 1'b0;
      end else if (start && !was_run && !(msat[k] && m_ovf[k])) begin
        m_run[k] = 1'b1;
        m_el[k]  = 0;
      end else if (was_run) begin
        m_el[k] = m_el[k] + 1;
        if (tk) begin
          if (m_count[k] == maxv) begin
            m_ovf[k] = 1'b1;
            if (msat[k]) m_run[k] = 1'b0;
            else         m_count[k] = 0;
          end else begin
            m_count[k] = m_count[k] + 1;
          end
        end
      end
    end
    m_cyc++;
  endtask

  task automatic check_all();
    chk("cnt_a", cnt_a, to_bcd(m_count[0]));
    chk("run_a", run_a, m_run[0]);
    chk("ovf_a", ovf_a, m_ovf[0]);
    chk("seg_a", seg_a, e_seg[0]);
    chk("sel_a", sel_a, e_sel[0]);
    chk("cnt_b", cnt_b, to_bcd(m_count[1]));
    chk("run_b", run_b, m_run[1]);
    chk("ovf_b", ovf_b, m_ovf[1]);
    chk("seg_b", seg_b, e_seg[1]);
    chk("sel_b", sel_b, e_sel[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    blank = 1'b0;
    model_reset();

    // Reset held, then released: first scanned output one edge later.
    @(negedge clk);
    check_all();
    run(3);
    chk("t1_sel_rst", sel_a, 2'b00);
    reset = 1'b0;
    cyc();
    chk("t1_sel", sel_a, 2'b01);
    chk("t1_seg", seg_a, 7'b0111111);
    chk("t1_sel_b", sel_b, 2'b10);

    // Start at edge 0, increments every TICK_DIV cycles; stop holds.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_run", run_a, 1'b1);
    run(3);
    chk("t2_cnt3", cnt_a, 8'h00);
    run(1);
    chk("t2_cnt4", cnt_a, 8'h01);
    run(32);
    chk("t2_cnt36", cnt_a, 8'h09);
    run(4);
    chk("t2_cnt40", cnt_a, 8'h10);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    run(20);
    chk("t2_hold", cnt_a, 8'h10);
    chk("t2_stopped", run_a, 1'b0);

    // Saturate on instance a, wrap on instance b.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(396);
    chk("t3_cnt99", cnt_a, 8'h99);
    chk("t3_cnt99_b", cnt_b, 8'h99);
    run(4);
    chk("t3_sat_cnt", cnt_a, 8'h99);
    chk("t3_sat_run", run_a, 1'b0);
    chk("t3_sat_ovf", ovf_a, 1'b1);
    chk("t4_wrap_cnt", cnt_b, 8'h00);
    chk("t4_wrap_ovf", ovf_b, 1'b1);
    chk("t4_wrap_run", run_b, 1'b1);
    run(4);
    chk("t4_wrap_next", cnt_b, 8'h01);
    start = 1'b1;
    run(20);
    start = 1'b0;
    chk("t3_start_ign", run_a, 1'b0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t3_clr_cnt", cnt_a, 8'h00);
    chk("t3_clr_ovf", ovf_a, 1'b0);

    // Count to 05, observe scanning, blanking and leading-zero suppression.
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(20);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t5_cnt05", cnt_b, 8'h05);
    run(8);
    blank = 1'b1;
    run(6);
    blank = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    run(6);

    // All commands together while running: clear wins.
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(148);
    chk("t6_cnt37", cnt_a, 8'h37);
    start = 1'b1;
    stop  = 1'b1;
    clear = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    chk("t6_all_cnt", cnt_a, 8'h00);
    chk("t6_all_run", run_a, 1'b0);

    // Randomized command traffic.
    for (int i = 0; i < 500; i++) begin
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 49) == 0);
      blank = ($urandom_range(0, 3) == 0);
      cyc();
    end
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    blank = 1'b0;

    // Asynchronous reset between edges.
    start = 1'b1;
    cyc();
    start = 1'b0;
    run(6);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    run(2);
    reset = 1'b0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
